// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : set_assoc_cache_ctrl
// Description : N-way (2 or 4) set-associative, write-through,
//               no-write-allocate data cache controller with tree pseudo-LRU
//               replacement, invalid-first victim choice, single-cycle flush
//               and saturating read hit/miss counters.
// Ports       : clk, rst (async, active-high)
//               cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ready
//               flush                 : invalidate all lines (IDLE, no request)
//               mem_rd/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_ready : backend
//               hit_count/miss_count  : saturating read statistics
// Revision    : 1.0 - initial release
// ============================================================================
module set_assoc_cache_ctrl #(
    parameter int NUM_WAYS   = 2,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10,
    parameter int DATA_BITS  = 32,
    parameter int CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [31:0]          cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic [DATA_BITS-1:0] cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [31:0]          mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [CNT_BITS-1:0]  hit_count,
    output logic [CNT_BITS-1:0]  miss_count
);

    localparam int c_SETS      = 2 ** INDEX_BITS;
    localparam int c_WAY_BITS  = $clog2(NUM_WAYS);
    localparam int c_PLRU_BITS = NUM_WAYS - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [NUM_WAYS-1:0]    r_valid [c_SETS];
    logic [TAG_BITS-1:0]    r_tag   [c_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0]   r_data  [c_SETS][NUM_WAYS];
    logic [c_PLRU_BITS-1:0] r_plru  [c_SETS];
    logic [CNT_BITS-1:0]    r_hit_cnt, r_miss_cnt;

    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic [NUM_WAYS-1:0]    w_hit_vec;
    logic                   w_hit, w_inv_found;
    logic [c_WAY_BITS-1:0]  w_hit_way, w_inv_way, w_plru_way, w_victim, w_acc_way;
    logic [c_PLRU_BITS-1:0] w_plru_cur, w_plru_upd;
    logic [DATA_BITS-1:0]   w_cpu_rdata;
    logic                   w_cpu_ready, w_mem_rd, w_mem_wr;
    logic                   w_rd_hit, w_rd_miss, w_fill, w_wr_upd, w_flush, w_touch;

    assign w_index = cpu_addr[INDEX_BITS+1:2];
    assign w_tag   = cpu_addr[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_hit
            assign w_hit_vec[w] = r_valid[w_index][w] && (r_tag[w_index][w] == w_tag);
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    // Hit way encode and lowest-numbered invalid way search.
    always_comb begin
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_hit_vec[w]) w_hit_way = c_WAY_BITS'(w);
            if (!r_valid[w_index][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_WAY_BITS'(w);
            end
        end
    end

    assign w_plru_cur = r_plru[w_index];
    assign w_victim   = w_inv_found ? w_inv_way : w_plru_way;
    // The way being touched is the refilled victim on a miss, the hit way otherwise.
    assign w_acc_way  = (r_state == ST_RD_MISS) ? w_victim : w_hit_way;

    // PLRU bits point at the side to replace next (0 = left / lower way);
    // an access flips every bit on its path to point away from it.
    generate
        if (NUM_WAYS == 2) begin : g_plru2
            assign w_plru_way = w_plru_cur;
            assign w_plru_upd = ~w_acc_way;
        end else begin : g_plru4
            assign w_plru_way = {w_plru_cur[0], w_plru_cur[0] ? w_plru_cur[2] : w_plru_cur[1]};
            always_comb begin
                w_plru_upd    = w_plru_cur;
                w_plru_upd[0] = ~w_acc_way[1];
                if (w_acc_way[1]) w_plru_upd[2] = ~w_acc_way[0];
                else              w_plru_upd[1] = ~w_acc_way[0];
            end
        end
    endgenerate

    assign w_rd_hit  = (r_state == ST_IDLE) && cpu_rd && w_hit;
    assign w_rd_miss = (r_state == ST_IDLE) && cpu_rd && !w_hit;
    assign w_fill    = (r_state == ST_RD_MISS) && mem_ready;
    assign w_wr_upd  = (r_state == ST_WR_THRU) && mem_ready && w_hit;
    assign w_flush   = (r_state == ST_IDLE) && !cpu_rd && !cpu_wr && flush;
    assign w_touch   = w_rd_hit || w_fill || w_wr_upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // A simultaneous read and write is served as a read only.
    always_comb begin
        w_state_next = r_state;
        w_cpu_ready  = 1'b0;
        w_cpu_rdata  = '0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_rd) begin
                    if (w_hit) begin
                        w_cpu_ready = 1'b1;
                        w_cpu_rdata = r_data[w_index][w_hit_way];
                    end else begin
                        w_state_next = ST_RD_MISS;
                    end
                end else if (cpu_wr) begin
                    w_state_next = ST_WR_THRU;
                end
            end
            ST_RD_MISS: begin
                w_mem_rd = 1'b1;
                if (mem_ready) begin
                    w_cpu_ready  = 1'b1;
                    w_cpu_rdata  = mem_rdata;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR_THRU: begin
                w_mem_wr = 1'b1;
                if (mem_ready) begin
                    w_cpu_ready  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, regardless of inputs.
    assign cpu_ready  = w_cpu_ready && !rst;
    assign cpu_rdata  = rst ? '0 : w_cpu_rdata;
    assign mem_rd     = w_mem_rd && !rst;
    assign mem_wr     = w_mem_wr && !rst;
    assign mem_addr   = cpu_addr;
    assign mem_wdata  = cpu_wdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Valid and PLRU state: cleared by reset and by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < c_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else if (w_flush) begin
            for (int s = 0; s < c_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            if (w_fill)  r_valid[w_index][w_victim] <= 1'b1;
            if (w_touch) r_plru[w_index]            <= w_plru_upd;
        end
    end

    // Tag and data arrays hold no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_index][w_victim]  <= w_tag;
            r_data[w_index][w_victim] <= mem_rdata;
        end else if (w_wr_upd) begin
            r_data[w_index][w_hit_way] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_rd_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (w_rd_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_assoc_cache_ctrl
// Description : Directed self-checking bench. Instance u_dut4 is a 4-way
//               cache with 16-bit counters; u_dut2 is a 2-way cache with
//               3-bit counters so counter saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, flush = 1'b0, mem_ready = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
    logic        b_cpu_rd = 1'b0, b_cpu_wr = 1'b0, b_flush = 1'b0;

    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
    logic        a_ready, a_mem_rd, a_mem_wr;
    logic [15:0] a_hit, a_miss;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic        b_ready, b_mem_rd, b_mem_wr;
    logic [2:0]  b_hit, b_miss;

    logic        sel = 1'b0;   // 0: drive/observe u_dut4, 1: u_dut2
    logic        s_ready, s_mem_rd;
    logic [31:0] s_rdata;
    assign s_ready  = sel ? b_ready  : a_ready;
    assign s_mem_rd = sel ? b_mem_rd : a_mem_rd;
    assign s_rdata  = sel ? b_rdata  : a_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic        h, dn, ir;
    logic [31:0] d, wd, wa;
    int          c;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.NUM_WAYS(4), .INDEX_BITS(6), .TAG_BITS(10), .DATA_BITS(32), .CNT_BITS(16)) u_dut4 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata), .cpu_ready(a_ready), .flush(flush),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(a_hit), .miss_count(a_miss));

    set_assoc_cache_ctrl #(.NUM_WAYS(2), .INDEX_BITS(6), .TAG_BITS(10), .DATA_BITS(32), .CNT_BITS(3)) u_dut2 (
        .clk(clk), .rst(rst), .cpu_rd(b_cpu_rd), .cpu_wr(b_cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata), .cpu_ready(b_ready), .flush(b_flush),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(b_hit), .miss_count(b_miss));

    // Read transaction on the selected instance; backend answers after lat
    // cycles of mem_rd. hit = ready in the request cycle; rdcyc counts mem_rd.
    task automatic do_read(input logic [31:0] addr, input int lat, input logic [31:0] rd,
                           output logic hit, output logic [31:0] data, output int rdcyc);
        logic done;
        @(negedge clk);
        cpu_addr = addr;
        if (sel) b_cpu_rd = 1'b1; else cpu_rd = 1'b1;
        #1;
        hit   = s_ready;
        data  = s_ready ? s_rdata : 32'hxxxx_xxxx;
        rdcyc = s_mem_rd ? 1 : 0;
        done  = s_ready;
        for (int k = 1; k <= lat + 4 && !done; k++) begin
            @(negedge clk);
            if (k == lat) begin mem_ready = 1'b1; mem_rdata = rd; end
            #1;
            if (s_mem_rd) rdcyc++;
            if (s_ready) begin done = 1'b1; data = s_rdata; end
        end
        @(negedge clk);
        cpu_rd = 1'b0; b_cpu_rd = 1'b0; mem_ready = 1'b0;
    endtask

    // Write transaction on u_dut4; fl drives flush while the write is in flight.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdat, input int lat,
                            input logic fl, output logic idle_rdy, output logic done,
                            output int wrcyc, output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
        @(negedge clk);
        cpu_addr = addr; cpu_wdata = wdat; cpu_wr = 1'b1;
        #1;
        idle_rdy   = a_ready;
        wrcyc      = a_mem_wr ? 1 : 0;
        done       = 1'b0;
        seen_addr  = 'x;
        seen_wdata = 'x;
        for (int k = 1; k <= lat + 4 && !done; k++) begin
            @(negedge clk);
            flush = fl;
            if (k == lat) mem_ready = 1'b1;
            #1;
            if (a_mem_wr) begin wrcyc++; seen_addr = a_mem_addr; seen_wdata = a_mem_wdata; end
            if (a_ready) done = 1'b1;
        end
        @(negedge clk);
        cpu_wr = 1'b0; mem_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        cpu_rd = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (a_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        n_checks++; if (a_mem_rd !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", a_mem_rd); end
        n_checks++; if (a_rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_checks++; if (a_hit !== 16'd0)    begin n_fail++; $display("FAIL reset_hit_count: got %0d want 0", a_hit); end
        n_checks++; if (a_miss !== 16'd0)   begin n_fail++; $display("FAIL reset_miss_count: got %0d want 0", a_miss); end
        @(negedge clk);
        cpu_rd = 1'b0; mem_ready = 1'b0; rst = 1'b0;
    endtask

    task automatic test_read_miss_hit();
        do_read(32'h000, 3, 32'hAAAA_0000, h, d, c);
        n_checks++; if (h !== 1'b0)          begin n_fail++; $display("FAIL first_read_hit: got %b want 0", h); end
        n_checks++; if (d !== 32'hAAAA_0000) begin n_fail++; $display("FAIL first_read_data: got %h want aaaa0000", d); end
        n_checks++; if (c != 3)              begin n_fail++; $display("FAIL first_read_mem_rd_cycles: got %0d want 3", c); end
        n_checks++; if (a_miss !== 16'd1)    begin n_fail++; $display("FAIL first_read_miss_count: got %0d want 1", a_miss); end
        do_read(32'h000, 3, 32'hDEAD_BEEF, h, d, c);
        n_checks++; if (h !== 1'b1)          begin n_fail++; $display("FAIL reread_hit: got %b want 1", h); end
        n_checks++; if (d !== 32'hAAAA_0000) begin n_fail++; $display("FAIL reread_data: got %h want aaaa0000", d); end
        n_checks++; if (c != 0)              begin n_fail++; $display("FAIL reread_mem_rd_cycles: got %0d want 0", c); end
        n_checks++; if (a_hit !== 16'd1)     begin n_fail++; $display("FAIL reread_hit_count: got %0d want 1", a_hit); end
    endtask

    task automatic test_plru4();
        // Ways 1..3 fill with tags 1..3 (invalid-first); then hit tag 0 and
        // bring in tag 4, which must evict way 2 (tag 2).
        for (int t = 1; t <= 3; t++) begin
            do_read(32'(t) << 8, 1, 32'hD000_0000 | 32'(t), h, d, c);
            n_checks++; if (h !== 1'b0 || d !== (32'hD000_0000 | 32'(t)))
                begin n_fail++; $display("FAIL plru4_fill_t%0d: got hit=%b data=%h want hit=0 data=%h", t, h, d, 32'hD000_0000 | 32'(t)); end
        end
        do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'hAAAA_0000) begin n_fail++; $display("FAIL plru4_hit_t0: got hit=%b data=%h want hit=1 data=aaaa0000", h, d); end
        do_read(32'h400, 1, 32'hD000_0004, h, d, c);
        n_checks++; if (h !== 1'b0 || d !== 32'hD000_0004) begin n_fail++; $display("FAIL plru4_miss_t4: got hit=%b data=%h want hit=0 data=d0000004", h, d); end
        do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'hAAAA_0000) begin n_fail++; $display("FAIL plru4_keep_t0: got hit=%b data=%h want hit=1 data=aaaa0000", h, d); end
        do_read(32'h100, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'hD000_0001) begin n_fail++; $display("FAIL plru4_keep_t1: got hit=%b data=%h want hit=1 data=d0000001", h, d); end
        do_read(32'h300, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'hD000_0003) begin n_fail++; $display("FAIL plru4_keep_t3: got hit=%b data=%h want hit=1 data=d0000003", h, d); end
        do_read(32'h400, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'hD000_0004) begin n_fail++; $display("FAIL plru4_keep_t4: got hit=%b data=%h want hit=1 data=d0000004", h, d); end
        n_checks++; if (a_hit !== 16'd6)  begin n_fail++; $display("FAIL plru4_hit_count: got %0d want 6", a_hit); end
        n_checks++; if (a_miss !== 16'd5) begin n_fail++; $display("FAIL plru4_miss_count: got %0d want 5", a_miss); end
    endtask

    task automatic test_plru2();
        logic [31:0] addrs [6] = '{32'h000, 32'h100, 32'h000, 32'h200, 32'h000, 32'h100};
        logic        hits  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] datas [6] = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0000,
                                   32'hB000_0002, 32'hB000_0000, 32'hB000_0001};
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_read(addrs[i], 2, datas[i], h, d, c);
            n_checks++; if (h !== hits[i] || d !== datas[i])
                begin n_fail++; $display("FAIL plru2_step%0d: got hit=%b data=%h want hit=%b data=%h", i, h, d, hits[i], datas[i]); end
        end
        n_checks++; if (b_miss !== 3'd4) begin n_fail++; $display("FAIL plru2_miss_count: got %0d want 4", b_miss); end
        n_checks++; if (b_hit !== 3'd2)  begin n_fail++; $display("FAIL plru2_hit_count: got %0d want 2", b_hit); end
        repeat (5) do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (b_hit !== 3'd7)  begin n_fail++; $display("FAIL cnt_reach_max: got %0d want 7", b_hit); end
        do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (b_hit !== 3'd7)  begin n_fail++; $display("FAIL cnt_saturate: got %0d want 7", b_hit); end
        sel = 1'b0;
    endtask

    task automatic test_write();
        do_write(32'h000, 32'h55, 2, 1'b0, ir, dn, c, wa, wd);
        n_checks++; if (ir !== 1'b0)  begin n_fail++; $display("FAIL wr_idle_ready: got %b want 0", ir); end
        n_checks++; if (dn !== 1'b1 || c != 2) begin n_fail++; $display("FAIL wr_hit_handshake: got done=%b mem_wr_cycles=%0d want done=1 cycles=2", dn, c); end
        n_checks++; if (wa !== 32'h000 || wd !== 32'h55) begin n_fail++; $display("FAIL wr_hit_bus: got addr=%h wdata=%h want 0/55", wa, wd); end
        n_checks++; if (a_hit !== 16'd6) begin n_fail++; $display("FAIL wr_no_count: got %0d want 6", a_hit); end
        do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'h55) begin n_fail++; $display("FAIL wr_hit_readback: got hit=%b data=%h want hit=1 data=55", h, d); end
        do_write(32'h500, 32'h77, 2, 1'b0, ir, dn, c, wa, wd);
        n_checks++; if (dn !== 1'b1 || c != 2 || wa !== 32'h500) begin n_fail++; $display("FAIL wr_miss_handshake: got done=%b cycles=%0d addr=%h want 1/2/500", dn, c, wa); end
        do_read(32'h500, 1, 32'hD000_0005, h, d, c);
        n_checks++; if (h !== 1'b0 || d !== 32'hD000_0005) begin n_fail++; $display("FAIL wr_no_allocate: got hit=%b data=%h want hit=0 data=d0000005", h, d); end
        n_checks++; if (a_miss !== 16'd6) begin n_fail++; $display("FAIL wr_miss_count: got %0d want 6", a_miss); end
    endtask

    task automatic test_flush();
        do_write(32'h000, 32'h66, 2, 1'b1, ir, dn, c, wa, wd);
        do_read(32'h000, 1, 32'h0, h, d, c);
        n_checks++; if (h !== 1'b1 || d !== 32'h66) begin n_fail++; $display("FAIL flush_in_wr_ignored: got hit=%b data=%h want hit=1 data=66", h, d); end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        do_read(32'h000, 1, 32'hD000_0000, h, d, c);
        n_checks++; if (h !== 1'b0 || d !== 32'hD000_0000) begin n_fail++; $display("FAIL flush_idle_miss: got hit=%b data=%h want hit=0 data=d0000000", h, d); end
        n_checks++; if (a_miss !== 16'd7 || a_hit !== 16'd8) begin n_fail++; $display("FAIL flush_counts: got hit=%0d miss=%0d want 8/7", a_hit, a_miss); end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        cpu_addr = 32'h700; cpu_rd = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (a_mem_rd !== 1'b1) begin n_fail++; $display("FAIL midmiss_mem_rd: got %b want 1", a_mem_rd); end
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF; rst = 1'b1;
        #1;
        n_checks++; if (a_mem_rd !== 1'b0) begin n_fail++; $display("FAIL midmiss_rst_mem_rd: got %b want 0", a_mem_rd); end
        n_checks++; if (a_ready !== 1'b0 || a_rdata !== 32'h0) begin n_fail++; $display("FAIL midmiss_rst_cpu: got ready=%b rdata=%h want 0/0", a_ready, a_rdata); end
        n_checks++; if (a_hit !== 16'd0 || a_miss !== 16'd0) begin n_fail++; $display("FAIL midmiss_rst_counts: got hit=%0d miss=%0d want 0/0", a_hit, a_miss); end
        @(negedge clk);
        cpu_rd = 1'b0; mem_ready = 1'b0; rst = 1'b0;
        do_read(32'h000, 1, 32'h1234_5678, h, d, c);
        n_checks++; if (h !== 1'b0 || d !== 32'h1234_5678) begin n_fail++; $display("FAIL after_rst_miss: got hit=%b data=%h want hit=0 data=12345678", h, d); end
        n_checks++; if (a_miss !== 16'd1) begin n_fail++; $display("FAIL after_rst_miss_count: got %0d want 1", a_miss); end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_plru4();
        test_plru2();
        test_write();
        test_flush();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
